// File: rtl/halt_unit_pkg.sv
// halt_unit shared types and widths.
// Optional stats ports: HALT_UNIT_STATS_EN.
package jpeb_pkg;

  localparam int REG_IDX_W = 3;
  localparam int XLEN      = 16;
  localparam int TMR_W     = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

endpackage

// File: rtl/halt_unit_if.sv
// Writeback/memory-side bundle for halt_unit.
// Stats signals exist only with HALT_UNIT_STATS_EN.
interface halt_unit_if;
  import jpeb_pkg::*;

  logic                 wb_valid;
  logic                 wb_is_halt;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 mem_busy;
  logic                 halt_pending;
  logic                 isHalt;
  logic [XLEN-1:0]      ret_val;
  logic                 drain_timeout;
`ifdef HALT_UNIT_STATS_EN
  logic [31:0]          retired_count;
  logic [31:0]          cycle_count;

  modport master (
    output wb_valid, wb_is_halt, wb_we,
    output wb_rd, wb_data, mem_busy,
    input  halt_pending, isHalt,
    input  ret_val, drain_timeout,
    input  retired_count, cycle_count
  );

  modport slave (
    input  wb_valid, wb_is_halt, wb_we,
    input  wb_rd, wb_data, mem_busy,
    output halt_pending, isHalt,
    output ret_val, drain_timeout,
    output retired_count, cycle_count
  );
`else
  modport master (
    output wb_valid, wb_is_halt, wb_we,
    output wb_rd, wb_data, mem_busy,
    input  halt_pending, isHalt,
    input  ret_val, drain_timeout
  );

  modport slave (
    input  wb_valid, wb_is_halt, wb_we,
    input  wb_rd, wb_data, mem_busy,
    output halt_pending, isHalt,
    output ret_val, drain_timeout
  );
`endif

endinterface

// File: rtl/halt_unit_drain_timer.sv
// Loadable down-counter bounding the DRAIN wait.
// Optional stats ports (HALT_UNIT_STATS_EN) live in the top.
module drain_timer
  import jpeb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_cnt;

  // Load on entry, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/halt_unit.sv
// Retire-side halt controller: shadow ret reg, drain, halt.
// Optional retire/cycle counters: HALT_UNIT_STATS_EN.
module halt_unit
  import jpeb_pkg::*;
#(
  parameter int RET_REG       = 1,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input logic        clk,
  input logic        rst,
  halt_unit_if.slave bus
);

  localparam logic [REG_IDX_W-1:0] RET_IDX = REG_IDX_W'(RET_REG);
  localparam logic [TMR_W-1:0]     TMO     = TMR_W'(DRAIN_TIMEOUT);
  localparam bit                   RET_R0  = (RET_REG == 0);

  halt_state_t     r_state;
  halt_state_t     w_next;
  logic            r_pending;
  logic            r_halt;
  logic            r_to;
  logic [XLEN-1:0] r_ret;
  logic            w_halt_in;
  logic            w_hit;
  logic            w_load;
  logic            w_set_to;
  logic            w_expired;

  assign w_halt_in = bus.wb_valid && bus.wb_is_halt;
  assign w_hit     = bus.wb_valid && bus.wb_we &&
                     (bus.wb_rd == RET_IDX) && !RET_R0;

  drain_timer u_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (TMO),
    .i_en       (r_state == DRAIN),
    .o_expired  (w_expired)
  );

  // Next-state: clean drain has priority over timeout.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_set_to = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_halt_in) begin
          w_next = DRAIN;
          w_load = 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.mem_busy) begin
          w_next = HALTED;
        end else if (w_expired) begin
          w_next   = HALTED;
          w_set_to = 1'b1;
        end
      end
      HALTED:  w_next = HALTED;
      default: w_next = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= RUN;
    else
      r_state <= w_next;
  end

  // Registered status flags; sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_halt    <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      if (w_next != RUN)    r_pending <= 1'b1;
      if (w_next == HALTED) r_halt    <= 1'b1;
      if (w_set_to)         r_to      <= 1'b1;
    end
  end

  // Shadow return register, live only in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ret <= '0;
    else if (r_state == RUN && w_hit)
      r_ret <= bus.wb_data;
  end

  assign bus.halt_pending  = r_pending;
  assign bus.isHalt        = r_halt;
  assign bus.ret_val       = r_ret;
  assign bus.drain_timeout = r_to;

`ifdef HALT_UNIT_STATS_EN
  logic [31:0] r_retired;
  logic [31:0] r_cycles;

  // Retire/cycle counters, frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
      r_cycles  <= '0;
    end else if (r_state != HALTED) begin
      r_cycles <= r_cycles + 32'd1;
      if (r_state == RUN && bus.wb_valid)
        r_retired <= r_retired + 32'd1;
    end
  end

  assign bus.retired_count = r_retired;
  assign bus.cycle_count   = r_cycles;
`endif

endmodule

// File: tb/tb_halt_unit.sv
// Bench for halt_unit: two configs vs a behavioural model.
// Stats checks active with HALT_UNIT_STATS_EN.
module tb_halt_unit;
  import jpeb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v, hl, we, busy;
  logic [2:0]  rd;
  logic [15:0] dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  halt_unit_if b0 ();
  halt_unit_if b1 ();

  assign b0.wb_valid   = v;
  assign b0.wb_is_halt = hl;
  assign b0.wb_we      = we;
  assign b0.wb_rd      = rd;
  assign b0.wb_data    = dat;
  assign b0.mem_busy   = busy;
  assign b1.wb_valid   = v;
  assign b1.wb_is_halt = hl;
  assign b1.wb_we      = we;
  assign b1.wb_rd      = rd;
  assign b1.wb_data    = dat;
  assign b1.mem_busy   = busy;

  halt_unit #(.RET_REG(1), .DRAIN_TIMEOUT(1024)) dut0 (
    .clk (clk), .rst (rst), .bus (b0)
  );
  halt_unit #(.RET_REG(3), .DRAIN_TIMEOUT(4)) dut1 (
    .clk (clk), .rst (rst), .bus (b1)
  );

  int          RET [2] = '{1, 3};
  int          TMO [2] = '{1024, 4};
  logic [15:0] m_ret [2];
  bit          m_dr [2];
  bit          m_hl [2];
  bit          m_to [2];
  int          m_w [2];
  logic [31:0] m_rc [2];
  logic [31:0] m_cc [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ret[i] = '0; m_dr[i] = 0; m_hl[i] = 0;
      m_to[i] = 0; m_w[i] = 0; m_rc[i] = '0; m_cc[i] = '0;
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!m_hl[i]) begin
        m_cc[i]++;
        if (!m_dr[i] && v) m_rc[i]++;
        if (m_dr[i]) begin
          m_w[i]++;
          if (!busy) m_hl[i] = 1;
          else if (m_w[i] == TMO[i] + 1) begin
            m_hl[i] = 1; m_to[i] = 1;
          end
        end else begin
          if (v && we && int'(rd) == RET[i] && RET[i] != 0)
            m_ret[i] = dat;
          if (v && hl) begin m_dr[i] = 1; m_w[i] = 0; end
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pend0"}, 32'(b0.halt_pending), 32'(m_dr[0] | m_hl[0]));
    chk({tag, ".halt0"}, 32'(b0.isHalt), 32'(m_hl[0]));
    chk({tag, ".ret0"}, 32'(b0.ret_val), 32'(m_ret[0]));
    chk({tag, ".to0"}, 32'(b0.drain_timeout), 32'(m_to[0]));
    chk({tag, ".pend1"}, 32'(b1.halt_pending), 32'(m_dr[1] | m_hl[1]));
    chk({tag, ".halt1"}, 32'(b1.isHalt), 32'(m_hl[1]));
    chk({tag, ".ret1"}, 32'(b1.ret_val), 32'(m_ret[1]));
    chk({tag, ".to1"}, 32'(b1.drain_timeout), 32'(m_to[1]));
`ifdef HALT_UNIT_STATS_EN
    chk({tag, ".rc0"}, b0.retired_count, m_rc[0]);
    chk({tag, ".cc0"}, b0.cycle_count, m_cc[0]);
    chk({tag, ".rc1"}, b1.retired_count, m_rc[1]);
    chk({tag, ".cc1"}, b1.cycle_count, m_cc[1]);
`endif
  endtask

  task automatic drive(bit iv, bit ih, bit iw, logic [2:0] ird,
                       logic [15:0] id, bit ib);
    v = iv; hl = ih; we = iw; rd = ird; dat = id; busy = ib;
  endtask

  task automatic idle(bit ib);
    drive(0, 0, 0, 3'd0, 16'h0, ib);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous pulse, checked before any clock edge.
  task automatic pulse_reset(string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".state0"}, 32'(dut0.r_state), 32'(RUN));
    chk({tag, ".state1"}, 32'(dut1.r_state), 32'(RUN));
    chk({tag, ".cnt0"}, 32'(dut0.u_tmr.r_cnt), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle(0);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("por");
    #10;
    rst = 1'b0;

    // Writes then halt.
    drive(1, 0, 1, 3'd1, 16'h0005, 0); step("wh.w1");
    drive(1, 0, 1, 3'd1, 16'h002A, 0); step("wh.w2");
    drive(1, 1, 0, 3'd0, 16'h0, 0);    step("wh.halt");
    chk("wh.nohalt_yet", 32'(b0.isHalt), 32'd0);
    idle(0);                           step("wh.h1");
    chk("wh.ishalt", 32'(b0.isHalt), 32'd1);
    chk("wh.retval", 32'(b0.ret_val), 32'h2A);
    chk("wh.noto", 32'(b0.drain_timeout), 32'd0);
    drive(1, 1, 1, 3'd1, 16'h7777, 0); step("wh.ignored");

    // Reset mid-DRAIN, then a normal halt.
    pulse_reset("rm.pre");
    drive(1, 1, 0, 3'd0, 16'h0, 1); step("rm.halt");
    idle(1); step("rm.d1");
    idle(1); step("rm.d2");
    pulse_reset("rm.rst");
    drive(1, 1, 0, 3'd0, 16'h0, 0); step("rm.halt2");
    idle(0); step("rm.done");
    chk("rm.ishalt", 32'(b0.isHalt), 32'd1);

    // Same-cycle write and halt; later write ignored.
    pulse_reset("sc.rst");
    drive(1, 1, 1, 3'd1, 16'hBEEF, 1); step("sc.halt");
    drive(1, 0, 1, 3'd1, 16'h1111, 1); step("sc.w");
    idle(0); step("sc.done");
    chk("sc.retval", 32'(b0.ret_val), 32'hBEEF);

    // Clean drain on dut0; dut1 (timeout 4) times out at edge 5.
    pulse_reset("cd.rst");
    drive(1, 1, 0, 3'd0, 16'h0, 1); step("cd.halt");
    for (int k = 1; k <= 7; k++) begin
      idle(1); step("cd.busy");
      if (k == 4) chk("to.early", 32'(b1.isHalt), 32'd0);
      if (k == 5) begin
        chk("to.ishalt", 32'(b1.isHalt), 32'd1);
        chk("to.flag", 32'(b1.drain_timeout), 32'd1);
      end
    end
    chk("cd.notyet", 32'(b0.isHalt), 32'd0);
    idle(0); step("cd.free");
    chk("cd.ishalt", 32'(b0.isHalt), 32'd1);
    chk("cd.noto", 32'(b0.drain_timeout), 32'd0);

    // 10 retirements over 25 cycles, last one a halt.
    pulse_reset("st.rst");
    for (int i = 0; i < 25; i++) begin
      if (i < 18 && i % 2 == 0)
        drive(1, 0, 1, 3'(i % 8), 16'(i), 0);
      else if (i == 18)
        drive(1, 1, 0, 3'd0, 16'h0, 0);
      else
        idle(0);
      step("st");
    end
`ifdef HALT_UNIT_STATS_EN
    chk("st.retired", b0.retired_count, 32'd10);
    chk("st.cycles", b0.cycle_count, 32'd20);
`endif

    // Randomised episodes.
    for (int e = 0; e < 8; e++) begin
      pulse_reset("rnd.rst");
      for (int c = 0; c < 40; c++) begin
        drive($urandom % 2 == 0, $urandom % 8 == 0,
              $urandom % 2 == 0,
              ($urandom % 2 == 0) ? 3'(1 + 2 * ($urandom % 2))
                                  : 3'($urandom % 8),
              16'($urandom), $urandom % 3 != 0);
        step("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
